// File: rtl/ov5640_reg_init.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ov5640_reg_init : OV5640 register-table init sequencer (SCCB writes/delays)
// Optional NACK retry via `INIT_RETRY_EN.                  Revision: 1.0
// ---------------------------------------------------------------------------
module ov5640_reg_init #(
  parameter int          TBL_LEN      = 252,
  parameter int          CLK_FREQ_KHZ = 24000,
  parameter int          MAX_RETRY    = 3,
  parameter logic [15:0] DELAY_TAG    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        power_on_vd,
  output logic [7:0]  tbl_addr,
  input  logic [23:0] tbl_data,
  output logic        sccb_req,
  output logic [15:0] sccb_addr,
  output logic [7:0]  sccb_data,
  input  logic        sccb_ack,
  input  logic        sccb_nack,
  output logic        busy,
  output logic        init_done,
  output logic        init_err
);

  localparam int                DCNT_W   = $clog2(255 * CLK_FREQ_KHZ + 1);
  localparam logic [DCNT_W-1:0] KHZ      = DCNT_W'(CLK_FREQ_KHZ);
  localparam logic [7:0]        LAST_IDX = 8'(TBL_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_LOAD     = 4'd2,
    S_REQ      = 4'd3,
    S_WAIT_ACK = 4'd4,
    S_DELAY    = 4'd5,
    S_NEXT     = 4'd6,
    S_DONE     = 4'd7,
    S_ERR      = 4'd8
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        idx;
  logic [DCNT_W-1:0] dly_cnt;
  logic              is_delay;
  logic              retry_ok;

  assign is_delay = (tbl_data[23:8] == DELAY_TAG);
  assign tbl_addr = idx;

`ifdef INIT_RETRY_EN
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [RTY_W-1:0] retry_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (state_nxt == S_IDLE || state == S_NEXT) begin
      retry_cnt <= '0;
    end else if (state == S_WAIT_ACK && state_nxt == S_REQ) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end

  assign retry_ok = (retry_cnt < RTY_W'(MAX_RETRY));
`else
  // Without retry support every NACK is fatal.
  assign retry_ok = (MAX_RETRY < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sccb_req  = 1'b0;
    busy      = 1'b0;
    init_done = 1'b0;
    init_err  = 1'b0;
    case (state)
      S_IDLE: begin
        if (power_on_vd) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy      = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy      = 1'b1;
        state_nxt = is_delay ? S_DELAY : S_REQ;
      end
      S_REQ: begin
        busy      = 1'b1;
        state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        busy     = 1'b1;
        sccb_req = 1'b1;
        if (sccb_ack) begin
          if (!sccb_nack)    state_nxt = S_NEXT;
          else if (retry_ok) state_nxt = S_REQ;
          else               state_nxt = S_ERR;
        end
      end
      S_DELAY: begin
        busy = 1'b1;
        // Counts 0 and 1 both leave after a single cycle.
        if (dly_cnt <= DCNT_W'(1)) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        busy      = 1'b1;
        state_nxt = (idx == LAST_IDX) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        init_done = 1'b1;
      end
      S_ERR: begin
        init_err = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // Sensor re-reset: abort wins over any pending ack.
    if (!power_on_vd && state != S_IDLE) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      dly_cnt   <= '0;
      sccb_addr <= '0;
      sccb_data <= '0;
    end else if (state_nxt == S_IDLE) begin
      idx       <= '0;
      dly_cnt   <= '0;
      sccb_addr <= '0;
      sccb_data <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (is_delay) begin
            dly_cnt <= DCNT_W'(tbl_data[7:0]) * KHZ;
          end else begin
            sccb_addr <= tbl_data[23:8];
            sccb_data <= tbl_data[7:0];
          end
        end
        S_DELAY: begin
          if (dly_cnt != '0) dly_cnt <= dly_cnt - 1'b1;
        end
        S_NEXT: begin
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ov5640_reg_init.sv
`default_nettype none
// Directed bench for ov5640_reg_init: 4-entry table with one 2 ms delay entry.
module tb_ov5640_reg_init;

  logic        clk = 1'b0;
  logic        rst;
  logic        power_on_vd;
  logic [7:0]  tbl_addr;
  logic [23:0] tbl_data = '0;
  logic        sccb_req;
  logic [15:0] sccb_addr;
  logic [7:0]  sccb_data;
  logic        sccb_ack;
  logic        sccb_nack;
  logic        busy;
  logic        init_done;
  logic        init_err;

  int tests = 0;
  int fails = 0;

  logic [23:0] rom [4];
  logic [23:0] reqs [$];
  logic        prev_req = 1'b0;
  logic [7:0]  prev_addr = '0;
  int          cyc = 0;
  int          t2 = 0;
  int          t3 = 0;
  logic        stable;

  ov5640_reg_init #(
    .TBL_LEN      (4),
    .CLK_FREQ_KHZ (10),
    .MAX_RETRY    (3),
    .DELAY_TAG    (16'hFFFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .power_on_vd (power_on_vd),
    .tbl_addr    (tbl_addr),
    .tbl_data    (tbl_data),
    .sccb_req    (sccb_req),
    .sccb_addr   (sccb_addr),
    .sccb_data   (sccb_data),
    .sccb_ack    (sccb_ack),
    .sccb_nack   (sccb_nack),
    .busy        (busy),
    .init_done   (init_done),
    .init_err    (init_err)
  );

  always #5 clk = ~clk;

  initial begin
    rom[0] = 24'h3008_82;
    rom[1] = 24'h3103_03;
    rom[2] = 24'hFFFF_02;
    rom[3] = 24'h4300_30;
  end

  // Synchronous table: data valid one cycle after the address changes.
  always @(posedge clk) tbl_data <= rom[tbl_addr[1:0]];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sccb_req && !prev_req) reqs.push_back({sccb_addr, sccb_data});
    prev_req <= sccb_req;
    if (tbl_addr != prev_addr) begin
      if (tbl_addr == 8'd2) t2 <= cyc;
      if (tbl_addr == 8'd3) t3 <= cyc;
    end
    prev_addr <= tbl_addr;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!sccb_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {63'd0, sccb_req}, 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!init_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, {62'd0, init_done, busy}, 64'b10);
  endtask

  task automatic ack_once(input logic nk, input int lat);
    repeat (lat) @(negedge clk);
    sccb_ack  = 1'b1;
    sccb_nack = nk;
    @(negedge clk);
    sccb_ack  = 1'b0;
    sccb_nack = 1'b0;
  endtask

  task automatic run_writes(input int n);
    for (int i = 0; i < n; i++) begin
      wait_req("write_req");
      ack_once(1'b0, 2);
    end
  endtask

  task automatic restart();
    power_on_vd = 1'b0;
    repeat (2) @(negedge clk);
    reqs.delete();
    power_on_vd = 1'b1;
  endtask

  function automatic logic [63:0] outs();
    return {28'd0, sccb_req, busy, init_done, init_err, tbl_addr, sccb_addr, sccb_data};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    power_on_vd = 1'b0;
    sccb_ack    = 1'b0;
    sccb_nack   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_pvd", outs(), 64'd0);

    // Start-up latency: busy one edge later, req on the fourth edge.
    power_on_vd = 1'b1;
    @(negedge clk);
    check("busy_first_edge", {63'd0, busy}, 64'd1);
    check("req_not_yet_1", {63'd0, sccb_req}, 64'd0);
    repeat (2) @(negedge clk);
    check("req_not_yet_3", {63'd0, sccb_req}, 64'd0);
    @(negedge clk);
    check("req_fourth_edge", {63'd0, sccb_req}, 64'd1);
    check("first_write", {40'd0, sccb_addr, sccb_data}, 64'h300882);

    // Normal run through all entries.
    for (int i = 0; i < 3; i++) begin
      wait_req("normal_req");
      ack_once(1'b0, 2);
      check("req_drop_after_ack", {63'd0, sccb_req}, 64'd0);
    end
    check("done_not_early", {63'd0, init_done}, 64'd0);
    @(negedge clk);
    check("done_after_last_next", {61'd0, init_done, busy, init_err}, 64'b100);
    check("normal_write_count", 64'(reqs.size()), 64'd3);
    if (reqs.size() == 3) begin
      check("normal_w0", {40'd0, reqs[0]}, 64'h300882);
      check("normal_w1", {40'd0, reqs[1]}, 64'h310303);
      check("normal_w2", {40'd0, reqs[2]}, 64'h430030);
    end
    check("delay_fetch_to_fetch", 64'(t3 - t2), 64'd23);
    repeat (5) @(negedge clk);
    check("done_sticky", {62'd0, init_done, busy}, 64'b10);

    // Slow master: request held stable while ack is withheld.
    restart();
    wait_req("stall_req");
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(sccb_req && sccb_addr == 16'h3008 && sccb_data == 8'h82)) stable = 1'b0;
    end
    check("stall_stable", {63'd0, stable}, 64'd1);
    ack_once(1'b0, 0);
    check("stall_req_drop", {63'd0, sccb_req}, 64'd0);
    run_writes(2);
    wait_done("stall_done");

`ifdef INIT_RETRY_EN
    // Entry 1 NACKed twice, then accepted.
    restart();
    run_writes(1);
    for (int k = 0; k < 2; k++) begin
      wait_req("retry_req");
      ack_once(1'b1, 1);
      check("retry_req_gap", {63'd0, sccb_req}, 64'd0);
      @(negedge clk);
      check("retry_req_back", {63'd0, sccb_req}, 64'd1);
    end
    ack_once(1'b0, 1);
    run_writes(1);
    wait_done("retry_done");
    check("retry_req_count", 64'(reqs.size()), 64'd5);
    check("retry_no_err", {63'd0, init_err}, 64'd0);

    // Entry 1 NACKed on every attempt: error after MAX_RETRY retries.
    restart();
    run_writes(1);
    for (int k = 0; k < 4; k++) begin
      wait_req("exhaust_req");
      ack_once(1'b1, 1);
    end
    repeat (40) @(negedge clk);
    check("exhaust_err", {60'd0, init_err, init_done, busy, sccb_req}, 64'b1000);
    check("exhaust_req_count", 64'(reqs.size()), 64'd5);
    check("exhaust_index", {56'd0, tbl_addr}, 64'd1);
`else
    // Any NACK is fatal without retry support.
    restart();
    wait_req("nack_req");
    ack_once(1'b1, 1);
    check("nack_err", {61'd0, init_err, sccb_req, init_done}, 64'b100);
    repeat (10) @(negedge clk);
    check("nack_err_sticky", {60'd0, init_err, init_done, busy, sccb_req}, 64'b1000);
    check("nack_req_count", 64'(reqs.size()), 64'd1);
`endif

    // power_on_vd dropped during the delay entry, then a clean restart.
    restart();
    run_writes(2);
    begin
      int n = 0;
      while (tbl_addr != 8'd2 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (6) @(negedge clk);
    check("abort_busy_before", {63'd0, busy}, 64'd1);
    power_on_vd = 1'b0;
    @(negedge clk);
    check("abort_outs_zero", outs(), 64'd0);
    reqs.delete();
    power_on_vd = 1'b1;
    run_writes(3);
    wait_done("abort_restart_done");
    check("abort_restart_count", 64'(reqs.size()), 64'd3);
    if (reqs.size() != 0) check("abort_restart_w0", {40'd0, reqs[0]}, 64'h300882);

    // Asynchronous reset while waiting for an ack.
    restart();
    wait_req("async_req");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outs", outs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ov5640_reg_init.md
# ov5640_reg_init

Register-initialisation sequencer for the OV5640 sensor, directly downstream of the power-on timing controller. It waits for the power-on-valid level, then walks a synchronous register table. Each entry is either one SCCB write request to the SCCB bus master or a millisecond delay. When the table is exhausted it flags completion, which releases the video capture path. A NACKed write leads to bounded retry or a sticky error.

## Interface
Parameters:
- `TBL_LEN`, default 252: number of table entries, indices 0..TBL_LEN-1.
- `CLK_FREQ_KHZ`, default 24000: clk cycles per millisecond.
- `MAX_RETRY`, default 3: extra attempts per NACKed write (only with `INIT_RETRY_EN`).
- `DELAY_TAG`, default 16'hFFFF: entry address that marks a delay entry.

Ports:
- `clk` in 1: system clock, 24 MHz nominal.
- `rst` in 1: asynchronous reset, active-high.
- `power_on_vd` in 1: level from the power-on controller; high means the sensor is ready for SCCB.
- `tbl_addr` out 8: table index.
- `tbl_data` in 24: {reg_addr[23:8], reg_data[7:0]}, valid 1 cycle after `tbl_addr` changes.
- `sccb_req` out 1: write request to the SCCB master.
- `sccb_addr` out 16: register address.
- `sccb_data` out 8: register data.
- `sccb_ack` in 1: 1-cycle pulse, transaction finished.
- `sccb_nack` in 1: sampled with `sccb_ack`; 1 means the slave NACKed.
- `busy` out 1: sequence in progress.
- `init_done` out 1: sticky, table completed.
- `init_err` out 1: sticky, write failed.

## Operation
FSM states: IDLE, FETCH, LOAD, REQ, WAIT_ACK, DELAY, NEXT, DONE, ERR.
- IDLE → FETCH when `power_on_vd`=1. The index, retry count and delay counter are cleared on entry.
- FETCH: drive `tbl_addr`=index, wait one cycle → LOAD.
- LOAD: capture `tbl_data`.
  - If reg_addr==`DELAY_TAG`: go to DELAY and load the counter with reg_data×`CLK_FREQ_KHZ`.
  - Otherwise: latch `sccb_addr`/`sccb_data` and go to REQ.
- REQ: assert `sccb_req` → WAIT_ACK.
- WAIT_ACK: hold `sccb_req`=1 with addr/data stable until `sccb_ack`.
  - ack with nack=0: deassert `sccb_req` in the same edge → NEXT.
  - ack with nack=1: retry or error, see Configuration.
- DELAY: decrement the counter to 0 → NEXT. A count of 0 means exit after one cycle. Counter width is ceil(log2(255×`CLK_FREQ_KHZ`+1)).
- NEXT: if index==`TBL_LEN`-1 → DONE; otherwise increment the index → FETCH.
- DONE: `init_done`=1, `busy`=0. Hold until reset or `power_on_vd` low.
- ERR: `init_err`=1, `busy`=0, `sccb_req`=0. Hold until reset or `power_on_vd` low.
- `power_on_vd` low in any non-IDLE state → IDLE next cycle; `sccb_req`, `busy`, `init_done` and `init_err` all go 0. This is the sensor re-reset case; the master aborts on req drop.
- `sccb_ack` outside WAIT_ACK is ignored.

## Timing
- Reset values:
  - `sccb_req`=0, `sccb_addr`=0, `sccb_data`=0, `tbl_addr`=0, `busy`=0, `init_done`=0, `init_err`=0, state IDLE.
- `power_on_vd` rising at edge N: `busy`=1 at N+1, `sccb_req`=1 at N+4 (FETCH, LOAD, REQ). `sccb_addr`/`sccb_data` are valid no later than `sccb_req`.
- Write entry overhead: 4 cycles plus master latency (NEXT, FETCH, LOAD, REQ).
- Delay entry of D ms: D×`CLK_FREQ_KHZ` + 3 cycles from FETCH to the next FETCH.
- `init_done` rises 1 cycle after the NEXT of the last entry. `busy` falls on the same edge.
- `power_on_vd` low and `sccb_ack` in the same cycle: the abort wins and the ack is discarded.

## Configuration
Macro `INIT_RETRY_EN`.
- Defined:
  - nack=1 with retry count < `MAX_RETRY`: increment the count, drop `sccb_req` for 1 cycle, → REQ (same entry).
  - nack=1 with retry count == `MAX_RETRY`: → ERR.
  - The count is cleared on every NEXT.
- Undefined: any nack=1 → ERR immediately. The retry counter is not built.

## Test plan
- TBL_LEN=4, CLK_FREQ_KHZ=10, table {3008/82, 3103/03, FFFF/02, 4300/30}, all acks clean:
  - three writes are issued in order, and exactly 20+3 cycles separate the second write's NEXT from the fourth entry's FETCH;
  - `init_done`=1 after the last ack, with `busy` 0.
- Master holds `sccb_ack` low for 50 cycles → `sccb_req`, `sccb_addr`, `sccb_data` stay stable for all 50 cycles; the ack pulse drops req on the next edge.
- `INIT_RETRY_EN` defined, MAX_RETRY=3, entry 1 NACKs twice then acks → 3 requests for entry 1, no `init_err`, `init_done`=1. Same bench with 4 NACKs → `init_err`=1 and no request for entry 2.
- `INIT_RETRY_EN` undefined, single NACK on entry 0 → `init_err`=1 one cycle after the ack, `sccb_req`=0, `init_done` stays 0.
- `power_on_vd` dropped during the DELAY entry, then reasserted → all outputs 0 within 1 cycle, then a full restart from index 0 and normal completion.
- `rst` asserted mid-WAIT_ACK, asynchronously between edges → all outputs go to their reset values immediately, with no clock edge needed.
